// File: rtl/bram_dual_client_arbiter.sv
// Two-writer / two-reader round-robin front end for a simple dual-port BRAM with 1-cycle registered read.
// Optional BRAM_CLEAR_EN: zero-fill sweep of the whole memory after reset before requests are accepted.
module bram_dual_client_arbiter #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  w0_req,
  input  logic [ADDR_WIDTH-1:0] w0_addr,
  input  logic [DATA_WIDTH-1:0] w0_data,
  output logic                  w0_gnt,
  input  logic                  w1_req,
  input  logic [ADDR_WIDTH-1:0] w1_addr,
  input  logic [DATA_WIDTH-1:0] w1_data,
  output logic                  w1_gnt,
  input  logic                  r0_req,
  input  logic [ADDR_WIDTH-1:0] r0_addr,
  output logic                  r0_gnt,
  output logic                  r0_rvalid,
  output logic [DATA_WIDTH-1:0] r0_rdata,
  input  logic                  r1_req,
  input  logic [ADDR_WIDTH-1:0] r1_addr,
  output logic                  r1_gnt,
  output logic                  r1_rvalid,
  output logic [DATA_WIDTH-1:0] r1_rdata,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_wr_addr,
  output logic [DATA_WIDTH-1:0] mem_wr_data,
  output logic [ADDR_WIDTH-1:0] mem_rd_addr,
  input  logic [DATA_WIDTH-1:0] mem_rd_data,
  output logic                  init_done
);

  logic                  run;
  logic                  clear_we;
  logic [ADDR_WIDTH-1:0] clear_addr;

`ifdef BRAM_CLEAR_EN
  typedef enum logic {CLEAR, RUN} state_t;
  state_t                state, state_next;
  logic [ADDR_WIDTH-1:0] clr_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= CLEAR;
      clr_cnt <= '0;
    end else begin
      state <= state_next;
      if (state == CLEAR) clr_cnt <= clr_cnt + 1'b1;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      CLEAR:   if (clr_cnt == '1) state_next = RUN;
      default: state_next = RUN;
    endcase
  end

  always_comb begin
    run        = (state == RUN);
    clear_we   = (state == CLEAR);
    clear_addr = clr_cnt;
  end
`else
  // No sweep: the arbiter is live exactly while reset is released.
  always_comb begin
    run        = rst_n;
    clear_we   = 1'b0;
    clear_addr = '0;
  end
`endif

  assign init_done = run;

  logic                  wptr, rptr;
  logic                  w_any, r0_ok, r1_ok;
  logic [ADDR_WIDTH-1:0] w_sel_addr;
  logic                  p1_valid, p1_id;

  always_comb begin
    w0_gnt     = run & w0_req & (~w1_req | ~wptr);
    w1_gnt     = run & w1_req & (~w0_req | wptr);
    w_any      = w0_gnt | w1_gnt;
    w_sel_addr = w1_gnt ? w1_addr : w0_addr;
    // A read hitting the address being written this cycle would sample stale data; hold it off one cycle.
    r0_ok      = r0_req & ~(w_any & (r0_addr == w_sel_addr));
    r1_ok      = r1_req & ~(w_any & (r1_addr == w_sel_addr));
    r0_gnt     = run & r0_ok & (~r1_ok | ~rptr);
    r1_gnt     = run & r1_ok & (~r0_ok | rptr);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr        <= 1'b0;
      rptr        <= 1'b0;
      mem_we      <= 1'b0;
      mem_wr_addr <= '0;
      mem_wr_data <= '0;
      mem_rd_addr <= '0;
      p1_valid    <= 1'b0;
      p1_id       <= 1'b0;
      r0_rvalid   <= 1'b0;
      r1_rvalid   <= 1'b0;
    end else begin
      if (run & w0_req & w1_req) wptr <= ~wptr;
      if (run & r0_ok & r1_ok)   rptr <= ~rptr;
      if (clear_we) begin
        mem_we      <= 1'b1;
        mem_wr_addr <= clear_addr;
        mem_wr_data <= '0;
      end else begin
        mem_we <= w_any;
        if (w_any) begin
          mem_wr_addr <= w_sel_addr;
          mem_wr_data <= w1_gnt ? w1_data : w0_data;
        end
      end
      if (r0_gnt | r1_gnt) mem_rd_addr <= r1_gnt ? r1_addr : r0_addr;
      p1_valid  <= r0_gnt | r1_gnt;
      p1_id     <= r1_gnt;
      r0_rvalid <= p1_valid & ~p1_id;
      r1_rvalid <= p1_valid & p1_id;
    end
  end

  assign r0_rdata = mem_rd_data;
  assign r1_rdata = mem_rd_data;

endmodule

// File: tb/tb_bram_dual_client_arbiter.sv
// Self-checking bench: DUT + read-first BRAM model, checked against a transaction-level reference
// (round-robin grant rules, shadow memory, queue of expected read returns). Honors BRAM_CLEAR_EN.
module tb_bram_dual_client_arbiter;
  localparam int DW = 32;
  localparam int AW = 10;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [1:0]    w_req = '0;
  logic [AW-1:0] w_addr [2];
  logic [DW-1:0] w_data [2];
  logic [1:0]    r_req = '0;
  logic [AW-1:0] r_addr [2];
  logic          w0_gnt, w1_gnt, r0_gnt, r1_gnt, r0_rvalid, r1_rvalid;
  logic [DW-1:0] r0_rdata, r1_rdata, mem_wr_data, mem_rd_data;
  logic          mem_we, init_done;
  logic [AW-1:0] mem_wr_addr, mem_rd_addr;

  always #5 clk = ~clk;

  bram_dual_client_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .w0_req(w_req[0]), .w0_addr(w_addr[0]), .w0_data(w_data[0]), .w0_gnt(w0_gnt),
    .w1_req(w_req[1]), .w1_addr(w_addr[1]), .w1_data(w_data[1]), .w1_gnt(w1_gnt),
    .r0_req(r_req[0]), .r0_addr(r_addr[0]), .r0_gnt(r0_gnt), .r0_rvalid(r0_rvalid), .r0_rdata(r0_rdata),
    .r1_req(r_req[1]), .r1_addr(r_addr[1]), .r1_gnt(r1_gnt), .r1_rvalid(r1_rvalid), .r1_rdata(r1_rdata),
    .mem_we(mem_we), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
    .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data), .init_done(init_done)
  );

  // Simple dual-port BRAM, read-first on same-edge collision.
  logic [DW-1:0] bram [DEPTH];
  always @(posedge clk) begin
    if (mem_we) bram[mem_wr_addr] <= mem_wr_data;
    mem_rd_data <= bram[mem_rd_addr];
  end

  typedef struct { int client; logic [DW-1:0] data; int due; } rd_t;
  rd_t           q[$];
  logic [DW-1:0] ref_mem [DEPTH];
  int            wptr = 0, rptr = 0, cyc = 0;
  int            ew_last, er_last;
  logic [1:0]    ow, orr;
  int            tests = 0, fails = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One RUN-mode clock cycle: inputs already driven; check at negedge, advance reference model.
  task automatic cycle();
    int ew, er;
    logic [1:0] el, erv;
    logic [DW-1:0] ed;
    @(negedge clk);
    ew = -1;
    if (w_req == 2'b11) ew = wptr; else if (w_req[0]) ew = 0; else if (w_req[1]) ew = 1;
    for (int k = 0; k < 2; k++) el[k] = r_req[k] && !(ew >= 0 && r_addr[k] == w_addr[ew]);
    er = -1;
    if (el == 2'b11) er = rptr; else if (el[0]) er = 0; else if (el[1]) er = 1;
    ow  = {w1_gnt, w0_gnt};
    orr = {r1_gnt, r0_gnt};
    chk("init_done", init_done, 1);
    chk("w0_gnt", w0_gnt, ew == 0);
    chk("w1_gnt", w1_gnt, ew == 1);
    chk("r0_gnt", r0_gnt, er == 0);
    chk("r1_gnt", r1_gnt, er == 1);
    erv = '0; ed = '0;
    if (q.size() != 0 && q[0].due == cyc) begin
      erv[q[0].client] = 1'b1;
      ed = q[0].data;
      void'(q.pop_front());
    end
    chk("r0_rvalid", r0_rvalid, erv[0]);
    chk("r1_rvalid", r1_rvalid, erv[1]);
    if (erv[0]) chk("r0_rdata", r0_rdata, ed);
    if (erv[1]) chk("r1_rdata", r1_rdata, ed);
    if (er >= 0) q.push_back('{client: er, data: ref_mem[r_addr[er]], due: cyc + 2});
    if (ew >= 0) ref_mem[w_addr[ew]] = w_data[ew];
    if (w_req == 2'b11) wptr = 1 - wptr;
    if (el == 2'b11) rptr = 1 - rptr;
    ew_last = ew; er_last = er;
    cyc++;
    @(posedge clk); #1;
  endtask

  // Called at posedge+1 right after reset release; returns at posedge+1 of the first RUN cycle.
  task automatic wait_init();
`ifdef BRAM_CLEAR_EN
    w_req = 2'b11; r_req = 2'b11;
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge clk);
      chk("clear_init_done", init_done, 0);
      chk("clear_gnt", {w0_gnt, w1_gnt, r0_gnt, r1_gnt}, 0);
      @(posedge clk); #1;
    end
    w_req = '0; r_req = '0;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
`endif
  endtask

  task automatic rand_phase(input int n);
    for (int i = 0; i < n; i++) begin
      cycle();
      for (int k = 0; k < 2; k++) begin
        if (!w_req[k] || ew_last == k) begin
          w_req[k]  = 1'($urandom_range(0, 1));
          w_addr[k] = AW'($urandom_range(0, 15));
          w_data[k] = $urandom;
        end
        if (!r_req[k] || er_last == k) begin
          r_req[k]  = 1'($urandom_range(0, 1));
          r_addr[k] = AW'($urandom_range(0, 15));
        end
      end
    end
    w_req = '0; r_req = '0;
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin w_addr[k] = '0; w_data[k] = '0; r_addr[k] = '0; end
    #2;
    chk("rst_mem_we", mem_we, 0);
    chk("rst_rvalid", {r0_rvalid, r1_rvalid}, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    wait_init();

    // 1: single writer fills memory, single reader reads it all back
    for (int i = 0; i < DEPTH; i++) begin
      w_req[0] = 1'b1; w_addr[0] = AW'(i); w_data[0] = 32'hA500_0000 + i;
      cycle();
    end
    w_req = '0;
    for (int i = 0; i < DEPTH; i++) begin
      r_req[0] = 1'b1; r_addr[0] = AW'(i);
      cycle();
    end
    r_req = '0;

    // 2: contended writers alternate, lone w1 granted every cycle
    w_req = 2'b11; w_addr[0] = 10'd5; w_addr[1] = 10'd6; w_data[0] = 32'h5; w_data[1] = 32'h6;
    for (int i = 0; i < 8; i++) begin
      cycle();
      chk("wr_alternate", ow, (i % 2 == 0) ? 2'b01 : 2'b10);
    end
    w_req = 2'b10;
    for (int i = 0; i < 4; i++) begin
      cycle();
      chk("w1_alone", ow, 2'b10);
    end
    w_req = '0;

    // 3: contended readers alternate, returns never overlap
    r_req = 2'b11; r_addr[0] = 10'd3; r_addr[1] = 10'd4;
    for (int i = 0; i < 10; i++) begin
      cycle();
      chk("rd_alternate", orr, (i % 2 == 0) ? 2'b01 : 2'b10);
      chk("rvalid_overlap", r0_rvalid & r1_rvalid, 0);
    end
    r_req = '0;
    repeat (3) cycle();

    // 4: same-cycle write/read address collision
    w_req[0] = 1'b1; w_addr[0] = 10'd7; w_data[0] = 32'hDEAD_BEEF;
    r_req[0] = 1'b1; r_addr[0] = 10'd7;
    cycle();
    chk("collision_block", orr, 2'b00);
    w_req = '0;
    cycle();
    chk("collision_retry", orr, 2'b01);
    r_req = '0;
    repeat (3) cycle();

    rand_phase(400);
    repeat (4) cycle();

    // 5: reset while a read is in flight
    r_req[1] = 1'b1; r_addr[1] = 10'd9;
    cycle();
    chk("r1_granted", orr, 2'b10);
    r_req = '0;
    #1 rst_n = 1'b0;
    w_req = 2'b11; r_req = 2'b11;
    #1;
    chk("rst_we", mem_we, 0);
    chk("rst_wr_addr", mem_wr_addr, 0);
    chk("rst_wr_data", mem_wr_data, 0);
    chk("rst_rd_addr", mem_rd_addr, 0);
    chk("rst_init_done", init_done, 0);
    q.delete();
    wptr = 0; rptr = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_gnt", {w0_gnt, w1_gnt, r0_gnt, r1_gnt}, 0);
      chk("rst_r1_rvalid", r1_rvalid, 0);
    end
    @(posedge clk); #1 rst_n = 1'b1;
    w_req = '0; r_req = '0;
    wait_init();
    w_req = 2'b11; w_addr[0] = 10'd20; w_addr[1] = 10'd21; w_data[0] = 32'h20; w_data[1] = 32'h21;
    r_req = 2'b11; r_addr[0] = 10'd22; r_addr[1] = 10'd23;
    cycle();
    chk("rr_restart_w", ow, 2'b01);
    chk("rr_restart_r", orr, 2'b01);
    w_req = '0; r_req = '0;
    repeat (3) cycle();

    // reads after reset (zeros if the clear sweep ran), mixed with new traffic
    rand_phase(300);
    repeat (4) cycle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end
endmodule
